// File: rtl/sig_pkg.sv
// Shared fixed-point breakpoints and segment encoding for the PLAN sigmoid pair.
// The forward sigmoid and its inverse must both take their breakpoints from here.
package sig_pkg;

  localparam int SIG_DATA_WIDTH  = 16;
  localparam int SIG_FRACT_WIDTH = 12;

  // Scales the fraction num / 2**log2den into Q(.)fw.
  function automatic int fx(input int num, input int log2den, input int fw);
    return num << (fw - log2den);
  endfunction

  localparam int HALF = fx(1, 1, SIG_FRACT_WIDTH);   // 0.5
  localparam int Q3   = fx(3, 2, SIG_FRACT_WIDTH);   // 0.75
  localparam int B2   = fx(59, 6, SIG_FRACT_WIDTH);  // 0.921875
  localparam int ONE  = fx(1, 0, SIG_FRACT_WIDTH);   // 1.0
  localparam int OFF2 = fx(5, 3, SIG_FRACT_WIDTH);   // 0.625
  localparam int OFF3 = fx(27, 5, SIG_FRACT_WIDTH);  // 0.84375
  localparam int XMAX = fx(5, 0, SIG_FRACT_WIDTH);   // 5.0

  typedef enum logic [1:0] {
    SEG1 = 2'd0,
    SEG2 = 2'd1,
    SEG3 = 2'd2,
    SAT  = 2'd3
  } seg_e;

endpackage

// File: rtl/sig_inv_seg.sv
// Folds a sigmoid value onto the upper half [0.5, 1) and classifies which
// PLAN segment it belongs to. Purely combinational.
module sig_inv_seg
  import sig_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int FRACT_WIDTH = 12
) (
  input  logic signed [DATA_WIDTH-1:0] y,
  output logic        [DATA_WIDTH-1:0] p,
  output logic                         neg,
  output seg_e                         seg
);

  localparam logic signed [DATA_WIDTH:0] HALF_C = (DATA_WIDTH+1)'(fx(1, 1, FRACT_WIDTH));
  localparam logic signed [DATA_WIDTH:0] Q3_C   = (DATA_WIDTH+1)'(fx(3, 2, FRACT_WIDTH));
  localparam logic signed [DATA_WIDTH:0] B2_C   = (DATA_WIDTH+1)'(fx(59, 6, FRACT_WIDTH));
  localparam logic signed [DATA_WIDTH:0] ONE_C  = (DATA_WIDTH+1)'(fx(1, 0, FRACT_WIDTH));

  logic signed [DATA_WIDTH:0] y_ext;
  logic signed [DATA_WIDTH:0] p_ext;

  // One extra bit keeps ONE - y exact for very negative y so it still saturates.
  always_comb begin
    y_ext = {y[DATA_WIDTH-1], y};
    neg   = (y_ext < HALF_C);
    p_ext = neg ? (ONE_C - y_ext) : y_ext;
    if (p_ext >= ONE_C)      seg = SAT;
    else if (p_ext >= B2_C)  seg = SEG3;
    else if (p_ext >= Q3_C)  seg = SEG2;
    else                     seg = SEG1;
    p = p_ext[DATA_WIDTH-1:0];
  end

endmodule

// File: rtl/sig_inv_pipe.sv
// Inverse PLAN sigmoid: three-stage pipeline (fold/classify, subtract,
// scale/clamp/sign) with a single advance enable shared by all stages.
module sig_inv_pipe
  import sig_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int FRACT_WIDTH = 12
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] Y,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] X,
  output logic                         sat
);

  localparam logic signed [DATA_WIDTH-1:0] HALF_C = DATA_WIDTH'(fx(1, 1, FRACT_WIDTH));
  localparam logic signed [DATA_WIDTH-1:0] OFF2_C = DATA_WIDTH'(fx(5, 3, FRACT_WIDTH));
  localparam logic signed [DATA_WIDTH-1:0] OFF3_C = DATA_WIDTH'(fx(27, 5, FRACT_WIDTH));
  localparam logic signed [DATA_WIDTH-1:0] XMAX_C = DATA_WIDTH'(fx(5, 0, FRACT_WIDTH));

  logic                         adv;
  logic [DATA_WIDTH-1:0]        p;
  logic                         neg;
  seg_e                         seg;

  logic                         s1_valid;
  logic [DATA_WIDTH-1:0]        s1_p;
  logic                         s1_neg;
  seg_e                         s1_seg;

  logic                         s2_valid;
  logic signed [DATA_WIDTH-1:0] s2_d;
  logic                         s2_neg;
  seg_e                         s2_seg;

  logic signed [DATA_WIDTH-1:0] off;
  logic signed [DATA_WIDTH-1:0] d_next;
  logic signed [DATA_WIDTH-1:0] m;
  logic signed [DATA_WIDTH-1:0] x_next;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  sig_inv_seg #(
    .DATA_WIDTH  (DATA_WIDTH),
    .FRACT_WIDTH (FRACT_WIDTH)
  ) u_seg (
    .y   (Y),
    .p   (p),
    .neg (neg),
    .seg (seg)
  );

  // Saturated samples carry a meaningless difference; the clamp ignores it.
  always_comb begin
    off = HALF_C;
    case (s1_seg)
      SEG2:    off = OFF2_C;
      SEG3:    off = OFF3_C;
      default: off = HALF_C;
    endcase
    d_next = s1_p - off;
  end

  always_comb begin
    m = XMAX_C;
    case (s2_seg)
      SEG1:    m = s2_d <<< 2;
      SEG2:    m = s2_d <<< 3;
      SEG3:    m = s2_d <<< 5;
      default: m = XMAX_C;
    endcase
    x_next = s2_neg ? -m : m;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid  <= 1'b0;
      s1_p      <= '0;
      s1_neg    <= 1'b0;
      s1_seg    <= SEG1;
      s2_valid  <= 1'b0;
      s2_d      <= '0;
      s2_neg    <= 1'b0;
      s2_seg    <= SEG1;
      out_valid <= 1'b0;
      X         <= '0;
      sat       <= 1'b0;
    end else if (adv) begin
      s1_valid  <= in_valid;
      s1_p      <= p;
      s1_neg    <= neg;
      s1_seg    <= seg;
      s2_valid  <= s1_valid;
      s2_d      <= d_next;
      s2_neg    <= s1_neg;
      s2_seg    <= s1_seg;
      out_valid <= s2_valid;
      X         <= x_next;
      sat       <= (s2_seg == SAT);
    end
  end

endmodule

// File: tb/tb_sig_inv_pipe.sv
// Directed and randomised checks of sig_inv_pipe against hand-computed values
// and an independent integer model of the inverse PLAN sigmoid.
module tb_sig_inv_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] Y;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] X;
  logic        sat;

  always #5 clk = ~clk;

  sig_inv_pipe #(
    .DATA_WIDTH  (16),
    .FRACT_WIDTH (12)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Y         (Y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .X         (X),
    .sat       (sat)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          n_out = 0;
  bit          chk_lat = 1'b0;
  bit          chk_rt = 1'b0;
  bit          saw_backpressure = 1'b0;
  bit          prev_stall = 1'b0;
  logic [15:0] prev_x;
  logic        prev_sat;

  logic [15:0] qx[$];
  logic        qs[$];
  int          qdue[$];
  logic [15:0] qy[$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Independent integer model: returns {sat, X}.
  function automatic logic [16:0] refInv(input logic [15:0] y);
    int yi, p, m, x;
    bit neg, s;
    logic [15:0] xs;
    yi  = int'(signed'(y));
    neg = (yi < 2048);
    p   = neg ? 4096 - yi : yi;
    s   = (p >= 4096);
    if (s)              m = 20480;
    else if (p >= 3776) m = (p - 3456) * 32;
    else if (p >= 3072) m = (p - 2560) * 8;
    else                m = (p - 2048) * 4;
    x  = neg ? -m : m;
    xs = x[15:0];
    return {s, xs};
  endfunction

  // Forward PLAN sigmoid, for round-trip checks.
  function automatic int planSig(input logic [15:0] xv);
    int xi, ax, s;
    xi = int'(signed'(xv));
    ax = (xi < 0) ? -xi : xi;
    if (ax >= 20480)     s = 4096;
    else if (ax >= 9728) s = (ax >> 5) + 3456;
    else if (ax >= 4096) s = (ax >> 3) + 2560;
    else                 s = (ax >> 2) + 2048;
    return (xi < 0) ? 4096 - s : s;
  endfunction

  function automatic bit rtEligible(input logic [15:0] y);
    int yi, p;
    yi = int'(signed'(y));
    p  = (yi < 2048) ? 4096 - yi : yi;
    return (p < 3072) || (p >= 3776 && p < 4096);
  endfunction

  // One cycle: drive at the falling edge, observe 1 time unit later.
  task automatic applyStimulus(input logic iv, input logic [15:0] y, input logic [15:0] ex,
                               input logic es, input logic ordy, output bit accepted);
    int d, diff;
    @(negedge clk);
    in_valid  = iv;
    Y         = y;
    out_ready = ordy;
    #1;
    cyc++;
    checkOutput("in_ready_rule", in_ready, !out_valid || out_ready);
    if (!in_ready) saw_backpressure = 1'b1;
    if (prev_stall) begin
      checkOutput("hold_valid", out_valid, 1);
      checkOutput("hold_x", X, prev_x);
      checkOutput("hold_sat", sat, prev_sat);
    end
    accepted = iv && in_ready;
    if (out_valid && out_ready) begin
      if (qx.size() == 0) begin
        checkOutput("spurious_out", out_valid, 0);
      end else begin
        checkOutput("x", X, qx[0]);
        checkOutput("sat", sat, qs[0]);
        d = qdue[0];
        if (chk_lat) checkOutput("latency", cyc, d);
        if (chk_rt && !qs[0] && rtEligible(qy[0])) begin
          diff = planSig(X) - int'(signed'(qy[0]));
          checkOutput("roundtrip", (diff <= 1 && diff >= -1), 1);
        end
        void'(qx.pop_front());
        void'(qs.pop_front());
        void'(qdue.pop_front());
        void'(qy.pop_front());
        n_out++;
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_x     = X;
    prev_sat   = sat;
    if (accepted) begin
      qx.push_back(ex);
      qs.push_back(es);
      qdue.push_back(cyc + 3);
      qy.push_back(y);
    end
  endtask

  task automatic drain();
    bit acc;
    for (int i = 0; i < 100 && qx.size() != 0; i++)
      applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, acc);
    checkOutput("drain_empty", qx.size(), 0);
  endtask

  logic [15:0] vec_y  [10] = '{16'h0EC0, 16'h0FFF, 16'h1000, 16'h0000, 16'h2000,
                               16'h0EBF, 16'h0141, 16'h07FF, 16'hFFFF, 16'h8000};
  logic [15:0] vec_x  [10] = '{16'h2800, 16'h4FE0, 16'h5000, 16'hB000, 16'h5000,
                               16'h25F8, 16'hDA08, 16'hFFFC, 16'hB000, 16'hB000};
  logic        vec_s  [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                               1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    #10_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit          acc;
    int          sent, n0;
    logic [16:0] r;
    logic [15:0] ry;
    logic [15:0] stall_y [8];

    rst = 1'b0; in_valid = 1'b0; Y = '0; out_ready = 1'b0;
    #12;
    checkOutput("reset_valid", out_valid, 0);
    checkOutput("reset_x", X, 16'h0000);
    checkOutput("reset_sat", sat, 0);
    checkOutput("reset_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b1;

    // Back-to-back samples should emerge on consecutive cycles.
    chk_lat = 1'b1;
    applyStimulus(1'b1, 16'h0800, 16'h0000, 1'b0, 1'b1, acc);
    checkOutput("accept_a0", acc, 1);
    applyStimulus(1'b1, 16'h0C00, 16'h1000, 1'b0, 1'b1, acc);
    checkOutput("accept_a1", acc, 1);
    applyStimulus(1'b1, 16'h0400, 16'hF000, 1'b0, 1'b1, acc);
    checkOutput("accept_a2", acc, 1);
    drain();

    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, vec_y[i], vec_x[i], vec_s[i], 1'b1, acc);
      checkOutput("accept_b", acc, 1);
    end
    drain();

    // Downstream stall while streaming eight samples.
    chk_lat = 1'b0;
    saw_backpressure = 1'b0;
    n0 = n_out;
    for (int i = 0; i < 8; i++) stall_y[i] = 16'(16'h0900 + i * 16'h0100);
    sent = 0;
    for (int c = 0; c < 60 && sent < 8; c++) begin
      r = refInv(stall_y[sent]);
      applyStimulus(1'b1, stall_y[sent], r[15:0], r[16], !(c >= 2 && c < 7), acc);
      if (acc) sent++;
    end
    checkOutput("stall_all_sent", sent, 8);
    drain();
    checkOutput("backpressure_seen", saw_backpressure, 1);
    checkOutput("stall_count", n_out - n0, 8);

    // Random handshakes against the model, with round-trip checks.
    chk_rt = 1'b1;
    n0 = n_out;
    sent = 0;
    for (int c = 0; c < 60000 && sent < 10000; c++) begin
      if ($urandom_range(0, 9) == 0) ry = 16'($urandom_range(0, 65535));
      else                           ry = 16'($urandom_range(0, 4096));
      r = refInv(ry);
      applyStimulus(1'($urandom_range(0, 1)), ry, r[15:0], r[16], 1'($urandom_range(0, 1)), acc);
      if (acc) sent++;
    end
    checkOutput("random_all_sent", sent, 10000);
    drain();
    checkOutput("random_count", n_out - n0, sent);
    chk_rt = 1'b0;

    // Asynchronous reset with samples in flight.
    applyStimulus(1'b1, 16'h0C00, 16'h1000, 1'b0, 1'b1, acc);
    applyStimulus(1'b1, 16'h0EC0, 16'h2800, 1'b0, 1'b1, acc);
    applyStimulus(1'b1, 16'h0400, 16'hF000, 1'b0, 1'b1, acc);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_rst_valid", out_valid, 0);
    checkOutput("async_rst_x", X, 16'h0000);
    checkOutput("async_rst_sat", sat, 0);
    qx.delete(); qs.delete(); qdue.delete(); qy.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, acc);
    chk_lat = 1'b1;
    n0 = n_out;
    applyStimulus(1'b1, 16'h0C00, 16'h1000, 1'b0, 1'b1, acc);
    checkOutput("post_rst_accept", acc, 1);
    drain();
    checkOutput("post_rst_count", n_out - n0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
